// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//
// Time-multiplexed seven-segment driver for a common-anode display.
// A packed BCD word and decimal-point mask are captured into shadow
// registers once per scan frame. One digit anode is lit at a time, with
// REFRESH_DIV clocks per digit slot. The first GUARD clocks of every slot
// keep all anodes off to suppress ghosting.
//
// Parameters:
//   DIGITS      number of digits scanned (1..8), digit 0 least significant
//   REFRESH_DIV clocks per digit slot (>= 2)
//   GUARD       blank clocks at the start of each slot (0 <= GUARD < REFRESH_DIV)
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous reset, active-low
//   En       in   display enable; low forces all anodes off
//   bcd      in   packed BCD, digit i at [4i+3:4i]
//   dp_mask  in   decimal-point request per digit, 1 = lit
//   an       out  anode selects, active-low, registered
//   seg      out  segments {g,f,e,d,c,b,a}, active-low, registered
//   dp       out  decimal point, active-low, registered
//
// Optional feature:
//   SEG_LZB_EN  when defined, leading-zero blanking is enabled. Digit i >= 1
//               is blanked when shadow digits i..DIGITS-1 are all zero and
//               its decimal point is not requested. Digit 0 is never blanked.
module seg7_scan_driver #(
    parameter int DIGITS      = 2,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  En,
    input  logic [4*DIGITS-1:0]   bcd,
    input  logic [DIGITS-1:0]     dp_mask,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int P_W   = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [P_W-1:0]   P_MAX   = P_W'(REFRESH_DIV - 1);
    localparam logic [P_W-1:0]   GUARD_P = P_W'(GUARD);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

    // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD codes show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b0111111;
        endcase
    endfunction

    logic [P_W-1:0]      p;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] bcd_s;
    logic [DIGITS-1:0]   dp_s;

    logic [3:0]          nib;
    logic                dp_req;
    logic [DIGITS-1:0]   an_sel;
    logic [DIGITS-1:0]   lz;
    logic                lz_act;
    logic                show;

`ifdef SEG_LZB_EN
    logic zero_above;

    // Walk from the most significant digit down; a digit is a leading zero
    // only while every digit at and above it is zero.
    always_comb begin
        lz         = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (bcd_s[4*i +: 4] == 4'd0);
            lz[i]      = zero_above && !dp_s[i];
        end
    end
`else
    assign lz = '0;
`endif

    always_comb begin
        nib    = 4'd0;
        dp_req = 1'b0;
        lz_act = 1'b0;
        an_sel = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nib       = bcd_s[4*i +: 4];
                dp_req    = dp_s[i];
                lz_act    = lz[i];
                an_sel[i] = 1'b0;
            end
        end
    end

    assign show = En && (p >= GUARD_P) && !lz_act;

    // Stage 0: slot prescaler, digit index and frame shadow.
    // Stage 1: registered pins, decoded from the stage-0 state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p     <= '0;
            idx   <= '0;
            bcd_s <= '0;
            dp_s  <= '0;
            an    <= '1;
            seg   <= 7'h7F;
            dp    <= 1'b1;
        end else begin
            if (p == P_MAX) begin
                p <= '0;
                if (idx == IDX_MAX) begin
                    // Capture only at the frame boundary so a frame is never torn.
                    idx   <= '0;
                    bcd_s <= bcd;
                    dp_s  <= dp_mask;
                end else begin
                    idx <= idx + 1'b1;
                end
            end else begin
                p <= p + 1'b1;
            end

            if (show) begin
                an  <= an_sel;
                seg <= seg_decode(nib);
                dp  <= ~dp_req;
            end else begin
                an  <= '1;
                seg <= 7'h7F;
                dp  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    localparam int DIGITS      = 2;
    localparam int REFRESH_DIV = 4;
    localparam int GUARD       = 1;

`ifdef SEG_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    localparam logic [9:0] BLANK = {2'b11, 7'h7F, 1'b1};
    localparam logic [6:0] S0    = 7'b1000000;
    localparam logic [6:0] S1    = 7'b1111001;
    localparam logic [6:0] S2    = 7'b0100100;
    localparam logic [6:0] S3    = 7'b0110000;
    localparam logic [6:0] S4    = 7'b0011001;
    localparam logic [6:0] S7    = 7'b1111000;
    localparam logic [6:0] SDASH = 7'b0111111;

    logic                clk = 1'b0;
    logic                rst;
    logic                En;
    logic [4*DIGITS-1:0] bcd;
    logic [DIGITS-1:0]   dp_mask;
    logic [DIGITS-1:0]   an;
    logic [6:0]          seg;
    logic                dp;

    logic [9:0] exp_q[$];
    logic [9:0] exp_e;
    int         checks = 0;
    int         errors = 0;

    seg7_scan_driver #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .GUARD       (GUARD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .En      (En),
        .bcd     (bcd),
        .dp_mask (dp_mask),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    always #5 clk = ~clk;

    // One clock: after the edge, queue what the pins must show for this cycle.
    task automatic cyc(input logic [9:0] e);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
    endtask

    // One digit slot: one guard clock followed by three lit clocks.
    task automatic slot(input logic [1:0] a, input logic [6:0] s, input logic d);
        cyc(BLANK);
        repeat (3) cyc({a, s, d});
    endtask

    // Slot 1 when the shadowed tens digit is zero with no decimal point.
    task automatic slot1_zero();
        if (LZB) slot(2'b11, 7'h7F, 1'b1);
        else     slot(2'b01, S0, 1'b1);
    endtask

    // Monitor: compare pins against the queued expectation mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_e = exp_q.pop_front();
                checks++;
                if ({an, seg, dp} !== exp_e) begin
                    errors++;
                    $display("FAIL pins chk%0d t=%0t: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                             checks, $time, an, seg, dp, exp_e[9:8], exp_e[7:1], exp_e[0]);
                end
            end
        end
    end

    initial begin
        rst     = 1'b0;
        En      = 1'b1;
        bcd     = 8'h42;
        dp_mask = 2'b00;

        // Held in reset: everything dark.
        repeat (3) cyc(BLANK);
        rst = 1'b1;

        // Frame 0 shows the reset shadow (zeros).
        slot(2'b10, S0, 1'b1);
        slot1_zero();

        // Frame 1 shows 42 captured at the end of frame 0.
        slot(2'b10, S2, 1'b1);
        slot(2'b01, S4, 1'b1);

        // Frame 2: bcd changes mid-slot 0, displayed frame stays 42.
        cyc(BLANK);
        cyc({2'b10, S2, 1'b1});
        bcd = 8'h17;
        cyc({2'b10, S2, 1'b1});
        cyc({2'b10, S2, 1'b1});
        slot(2'b01, S4, 1'b1);

        // Frame 3 shows 17.
        slot(2'b10, S7, 1'b1);
        bcd = 8'h07;
        slot(2'b01, S1, 1'b1);

        // Frame 4 shows 07 (leading zero).
        slot(2'b10, S7, 1'b1);
        bcd = 8'h00;
        slot1_zero();

        // Frame 5 shows 00; digit 0 always lit.
        slot(2'b10, S0, 1'b1);
        bcd     = 8'h3A;
        dp_mask = 2'b10;
        slot1_zero();

        // Frame 6 shows dash and 3 with decimal point.
        slot(2'b10, SDASH, 1'b1);
        slot(2'b01, S3, 1'b0);

        // Frame 7: En low for 5 clocks mid-slot 0.
        cyc(BLANK);
        cyc({2'b10, SDASH, 1'b1});
        En = 1'b0;
        repeat (5) cyc(BLANK);
        En = 1'b1;
        cyc({2'b01, S3, 1'b0});

        // Frame 8: sequence resumes unshifted.
        slot(2'b10, SDASH, 1'b1);
        slot(2'b01, S3, 1'b0);

        // Frame 9: reset asserted mid-slot blanks within the same cycle.
        cyc(BLANK);
        cyc({2'b10, SDASH, 1'b1});
        @(posedge clk);
        #1;
        exp_q.push_back(BLANK);
        #1;
        rst = 1'b0;
        repeat (2) cyc(BLANK);
        rst = 1'b1;

        // Restart from slot 0 with the shadow cleared.
        slot(2'b10, S0, 1'b1);
        slot1_zero();

        // Next frame shows the 3A captured at the end of the restart frame.
        slot(2'b10, SDASH, 1'b1);
        slot(2'b01, S3, 1'b0);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed seven-segment display driver sitting directly downstream of the BCD up-counter. Captures a packed BCD word once per scan frame, cycles one digit anode at a time at a programmable refresh rate, decodes the active digit to active-low segments, and inserts a ghost-suppression guard interval at every digit switch. Drives the board's common-anode display directly.

## Interface
- `DIGITS`, 2: number of digits scanned (1..8); digit 0 is least significant.
- `REFRESH_DIV`, 100000: clocks per digit slot (≥2); 1 kHz per digit at 100 MHz.
- `GUARD`, 16: clocks at the start of each slot with all anodes off (0 ≤ GUARD < REFRESH_DIV).
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `En`  in  1  display enable; low forces all anodes off.
- `bcd`  in  4*DIGITS  packed BCD, digit i at [4i+3:4i].
- `dp_mask`  in  DIGITS  decimal-point request per digit, 1 = lit.
- `an`  out  DIGITS  anode selects, active-low, registered.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- `dp`  out  1  decimal point, active-low, registered.

## Operation
- State: prescaler `p` (0..REFRESH_DIV-1), digit index `idx` (0..DIGITS-1), shadow `bcd_s`/`dp_s`.
- Slot tick when `p == REFRESH_DIV-1`: `p` → 0, `idx` → idx+1, wrapping DIGITS-1 → 0; else `p` increments.
- Frame capture: on a tick with `idx == DIGITS-1`, `bcd_s <= bcd`, `dp_s <= dp_mask`. Mid-frame input changes never alter the displayed frame (no tearing).
- Output rule, every cycle, from state of previous cycle: anode `idx` active (all others 1) iff `En == 1` and `p >= GUARD`; otherwise `an` all 1, `seg = 7'h7F`, `dp = 1`.
- Decode of active nibble: 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000; 10..15 (non-BCD) → 0111111 (dash).
- `dp = ~dp_s[idx]` while anode active.
- `En` gates outputs only; `p`, `idx`, and frame capture keep running.

## Timing
- Reset (asserted, asynchronous): `p`=0, `idx`=0, `bcd_s`=0, `dp_s`=0, `an` all 1, `seg`=7'h7F, `dp`=1.
- Output latency: one clock from state to pins.
- Each digit lit for REFRESH_DIV-GUARD clocks per slot; frame period DIGITS*REFRESH_DIV clocks.
- First frame after reset displays shadow zeros; `bcd` sampled at end of first frame is shown from slot 0 of the second frame.
- Reset asserted mid-slot blanks outputs immediately and restarts at slot 0 on release.
- DIGITS = 1: `idx` constant 0, capture at every tick.
- GUARD = 0: no blanking interval; anode switches directly between digits.

## Configuration
- `SEG_LZB_EN` defined: leading-zero blanking. Digit i ≥ 1 blanked (anode off, `seg`=7'h7F, `dp`=1) when `bcd_s` digits i..DIGITS-1 are all 0 and `dp_s[i]` is 0. Digit 0 never blanked.
- `SEG_LZB_EN` undefined: every digit displayed, including leading zeros.

## Test plan
Bench parameters: DIGITS=2, REFRESH_DIV=4, GUARD=1.
- Assert `rst`=0 mid-run → `an`=2'b11, `seg`=7'h7F, `dp`=1 in the same cycle, held until release.
- `En`=1, `bcd`=8'h42 held from reset → second frame: slot 0 `an`=10 with `seg`=0100100 for 3 clocks, slot 1 `an`=01 with `seg`=0011001 for 3 clocks, 1 blank clock before each.
- `bcd` switched 8'h42→8'h17 during slot 0 → remainder of frame still shows 4 in slot 1; next frame shows 7 then 1.
- `bcd`=8'h07 → with `SEG_LZB_EN`, slot 1 `an`=11; without it, slot 1 `seg`=1000000. `bcd`=8'h00 → digit 0 always shows 1000000.
- `bcd`=8'h3A, `dp_mask`=2'b10 → slot 0 `seg`=0111111, slot 1 `seg`=0110000 with `dp`=0.
- `En` dropped for 5 clocks mid-slot → `an`=11 one clock later; slot/frame sequence resumes unshifted when `En` returns.
